// File: rtl/pc_fetch_seq.sv
// Next-PC producer and instruction-fetch sequencer for the MIPS front end.
// Optional FETCH_CNT_EN adds a saturating count of captured fetches.
module pc_fetch_seq #(
  parameter int unsigned AW = 6,
  parameter int unsigned IW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] PCO,
  output logic [AW-1:0] PCI,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_target
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]   fetch_cnt
`endif
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          imem_req_q, imem_req_d;
  logic          instr_valid_q, instr_valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          squash_q, squash_d;
  logic          ack_accept;
  logic [AW-1:0] pc_inc;

  assign pc_inc = PCO + AW'(1);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      squash_q      <= squash_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    squash_d      = squash_q;
    ack_accept    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        // The request already went out with the old PC.
        if (redir_valid) squash_d = 1'b1;
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (squash_q || redir_valid) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            ack_accept    = 1'b1;
            instr_d       = imem_rdata;
            instr_pc_d    = PCO;
            instr_valid_d = 1'b1;
            state_d       = S_FULL;
          end
        end else if (redir_valid) begin
          squash_d = 1'b1;
        end
      end
      S_FULL: begin
        if (redir_valid || instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_REQ);
  end

  // Next PC: reset forces 0 so the un-reset PC register starts clean.
  always_comb begin
    PCI = PCO;
    if (!RST_N)          PCI = '0;
    else if (redir_valid) PCI = redir_target;
    else if (ack_accept)  PCI = pc_inc;
  end

  assign imem_addr   = PCO;
  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef FETCH_CNT_EN
  logic [CW-1:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (ack_accept && (fetch_cnt_q != {CW{1'b1}})) fetch_cnt_d = fetch_cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) fetch_cnt_q <= '0;
    else        fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with a bench-side PC register model.
// Define FETCH_CNT_EN to also check the fetch counter.
module tb_pc_fetch_seq;

  logic        CLK;
  logic        RST_N;
  logic [5:0]  pc_q;
  logic [5:0]  PCI;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  instr_pc;
  logic        redir_valid;
  logic [5:0]  redir_target;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_seq #(.AW(6), .IW(32)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .PCO          (pc_q),
    .PCI          (PCI),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .redir_valid  (redir_valid),
    .redir_target (redir_target)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External PC register: loads PCI every rising edge, no reset of its own.
  always_ff @(posedge CLK) pc_q <= PCI;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starts in S_REQ just after an edge; ends just after entering S_FULL.
  task automatic fetch_one(input logic [5:0] a, input logic [31:0] d);
    logic [5:0] nxt;
    nxt = a + 6'd1;
    check("req_high", 32'(imem_req), 32'd1);
    check("req_addr", 32'(imem_addr), 32'(a));
    tick();
    check("req_low_wait", 32'(imem_req), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = d;
    #1;
    check("pci_inc", 32'(PCI), 32'(nxt));
    tick();
    imem_ack = 1'b0;
    check("valid_set", 32'(instr_valid), 32'd1);
    check("instr_data", instr, d);
    check("instr_pc", 32'(instr_pc), 32'(a));
    check("pco_adv", 32'(pc_q), 32'(nxt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_ipc"}, 32'(instr_pc), 32'd0);
    check({tag, "_pci"}, 32'(PCI), 32'd0);
`ifdef FETCH_CNT_EN
    check({tag, "_cnt"}, 32'(fetch_cnt), 32'd0);
`endif
  endtask

  initial begin
    RST_N        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    instr_ready  = 1'b1;
    redir_valid  = 1'b0;
    redir_target = '0;

    // Reset and straight-line fetch of PCs 0,1,2
    tick();
    tick();
    check_reset_outputs("rst");
    RST_N = 1'b1;
    #1;
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_pci", 32'(PCI), 32'd0);
    tick();
    fetch_one(6'd0, 32'hA000_0000);
    tick();
    check("consumed", 32'(instr_valid), 32'd0);
    fetch_one(6'd1, 32'hA000_0001);
    tick();
    fetch_one(6'd2, 32'hA000_0002);

    // Redirect to 63 from S_FULL, then wrap to 0
    redir_valid  = 1'b1;
    redir_target = 6'd63;
    #1;
    check("redir_full_pci", 32'(PCI), 32'd63);
    tick();
    redir_valid = 1'b0;
    check("redir_full_valid", 32'(instr_valid), 32'd0);
    fetch_one(6'd63, 32'h1234_5678);

    // Decode stalls five cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, 32'h1234_5678);
      check("stall_ipc", 32'(instr_pc), 32'd63);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_pci", 32'(PCI), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    fetch_one(6'd0, 32'h0BAD_F00D);
    tick();

    // Redirect while waiting; the late ack must be dropped
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", 32'(imem_addr), 32'd1);
    tick();
    redir_valid  = 1'b1;
    redir_target = 6'd20;
    #1;
    check("t4_pci_redir", 32'(PCI), 32'd20);
    tick();
    redir_valid = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("t4_pci_drop", 32'(PCI), 32'd20);
    tick();
    imem_ack = 1'b0;
    check("t4_valid", 32'(instr_valid), 32'd0);
    check("t4_req2", 32'(imem_req), 32'd1);
    check("t4_addr2", 32'(imem_addr), 32'd20);

    // Redirect coincident with ack
    tick();
    imem_ack     = 1'b1;
    imem_rdata   = 32'hCAFE_0001;
    redir_valid  = 1'b1;
    redir_target = 6'd8;
    #1;
    check("t5_pci", 32'(PCI), 32'd8);
    tick();
    imem_ack    = 1'b0;
    redir_valid = 1'b0;
    check("t5_valid", 32'(instr_valid), 32'd0);
    fetch_one(6'd8, 32'hCAFE_0008);

    // Redirect in S_FULL with decode not ready
    instr_ready = 1'b0;
    tick();
    check("t5_hold", 32'(instr_valid), 32'd1);
    redir_valid  = 1'b1;
    redir_target = 6'd12;
    #1;
    check("t5_full_pci", 32'(PCI), 32'd12);
    tick();
    redir_valid = 1'b0;
    check("t5_full_drop", 32'(instr_valid), 32'd0);
    check("t5_full_addr", 32'(imem_addr), 32'd12);

    // Redirect during the request cycle squashes that fetch
    redir_valid  = 1'b1;
    redir_target = 6'd30;
    #1;
    check("sq_pci", 32'(PCI), 32'd30);
    tick();
    redir_valid = 1'b0;
    check("sq_req_low", 32'(imem_req), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    #1;
    check("sq_pci_drop", 32'(PCI), 32'd30);
    tick();
    imem_ack = 1'b0;
    check("sq_valid", 32'(instr_valid), 32'd0);
    fetch_one(6'd30, 32'h3000_0030);
`ifdef FETCH_CNT_EN
    check("cnt_total", 32'(fetch_cnt), 32'd7);
`endif

    // Reset mid-fetch with an ack arriving during reset
    instr_ready = 1'b1;
    tick();
    tick();
    check("pre_rst_wait", 32'(imem_req), 32'd0);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_0000;
    tick();
    imem_ack = 1'b0;
    check_reset_outputs("mid_rst2");
    check("mid_rst_pco", 32'(pc_q), 32'd0);
    RST_N    = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("stale_valid", 32'(instr_valid), 32'd0);
    fetch_one(6'd0, 32'h7777_0000);
`ifdef FETCH_CNT_EN
    check("cnt_after_rst", 32'(fetch_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
